// File: rtl/pico_pkg.sv
// Shared types and sizing for the PicoMIPS register file and writeback stage.
// N/NREG live here so the package, interface and RTL always agree on widths.
package pico_pkg;
    localparam int N    = 8;
    localparam int NREG = 8;
    localparam int AW   = $clog2(NREG);

    typedef logic [AW-1:0]       reg_addr_t;
    typedef logic signed [N-1:0] data_t;

    localparam reg_addr_t R0      = '0;
    localparam reg_addr_t OUT_REG = reg_addr_t'(NREG - 1);

    typedef struct packed {
        logic      valid;
        reg_addr_t addr;
        data_t     data;
    } wb_stage_t;
endpackage

// File: rtl/pico_regfile_wb_if.sv
// Writeback request, two read ports and status outputs of the PicoMIPS register file.
// The datapath side uses master; the register file uses slave.
interface pico_regfile_wb_if;
    import pico_pkg::*;

    logic      wb_valid;
    reg_addr_t wb_addr;
    data_t     wb_data;
    reg_addr_t ra_addr;
    reg_addr_t rb_addr;
    data_t     ra_data;
    data_t     rb_data;
    logic      hazard;
    data_t     out_reg;

    modport master (
        output wb_valid, wb_addr, wb_data, ra_addr, rb_addr,
        input  ra_data, rb_data, hazard, out_reg
    );

    modport slave (
        input  wb_valid, wb_addr, wb_data, ra_addr, rb_addr,
        output ra_data, rb_data, hazard, out_reg
    );
endinterface

// File: rtl/pico_regarray.sv
// NREG x N register array: one synchronous write port, two asynchronous read ports.
// r0 is never written and always reads as zero; synchronous reset clears every entry.
module pico_regarray
    import pico_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      we_i,
    input  reg_addr_t waddr_i,
    input  data_t     wdata_i,
    input  reg_addr_t raddr_a_i,
    input  reg_addr_t raddr_b_i,
    output data_t     rdata_a_o,
    output data_t     rdata_b_o
);
    data_t mem_q [NREG];

    // Reset wins over a write on the same edge, so a pending commit is dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != R0)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = (raddr_a_i == R0) ? data_t'(0) : mem_q[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == R0) ? data_t'(0) : mem_q[raddr_b_i];
endmodule

// File: rtl/pico_regfile_wb.sv
// Register file plus one-deep writeback stage; writes land in the array two edges after presentation.
// Optional BYPASS_EN forwards the staged value to the read ports and ties hazard low.
module pico_regfile_wb
    import pico_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    pico_regfile_wb_if.slave         bus
);
    wb_stage_t stage_q, stage_d;
    data_t     out_reg_q;
    data_t     arr_a, arr_b;

    always_comb begin
        stage_d       = '0;
        stage_d.valid = bus.wb_valid && (bus.wb_addr != R0);
        stage_d.addr  = bus.wb_addr;
        stage_d.data  = bus.wb_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q   <= '0;
            out_reg_q <= '0;
        end else begin
            stage_q <= stage_d;
            if (stage_q.valid && (stage_q.addr == OUT_REG)) begin
                out_reg_q <= stage_q.data;
            end
        end
    end

    pico_regarray u_regarray (
        .clk_i     (clk),
        .rst_i     (reset),
        .we_i      (stage_q.valid),
        .waddr_i   (stage_q.addr),
        .wdata_i   (stage_q.data),
        .raddr_a_i (bus.ra_addr),
        .raddr_b_i (bus.rb_addr),
        .rdata_a_o (arr_a),
        .rdata_b_o (arr_b)
    );

`ifdef BYPASS_EN
    // stage_q.valid already excludes r0, so r0 can never be forwarded.
    assign bus.ra_data = (stage_q.valid && (stage_q.addr == bus.ra_addr)) ? stage_q.data : arr_a;
    assign bus.rb_data = (stage_q.valid && (stage_q.addr == bus.rb_addr)) ? stage_q.data : arr_b;
    assign bus.hazard  = 1'b0;
`else
    assign bus.ra_data = arr_a;
    assign bus.rb_data = arr_b;
    assign bus.hazard  = stage_q.valid &&
                         ((stage_q.addr == bus.ra_addr) || (stage_q.addr == bus.rb_addr));
`endif

    assign bus.out_reg = out_reg_q;
endmodule

// File: tb/tb_pico_regfile_wb.sv
// Directed bench for pico_regfile_wb (default build, no forwarding): vector table plus reset corner sequences.
module tb_pico_regfile_wb;
    import pico_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_total = 0;
    int   n_pass  = 0;

    pico_regfile_wb_if bus ();

    pico_regfile_wb dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [2:0] wa;
        logic [7:0] wd;
        logic [2:0] ra;
        logic [2:0] rb;
        logic [7:0] e_ra;
        logic [7:0] e_rb;
        logic       e_hz;
        logic [7:0] e_out;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    endtask

    task automatic drive(input logic v, input logic [2:0] wa, input logic [7:0] wd,
                         input logic [2:0] ra, input logic [2:0] rb);
        bus.wb_valid = v;
        bus.wb_addr  = wa;
        bus.wb_data  = wd;
        bus.ra_addr  = ra;
        bus.rb_addr  = rb;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [7:0] e_ra, input logic [7:0] e_rb,
                           input logic e_hz, input logic [7:0] e_out);
        chk({tag, ".ra_data"}, bus.ra_data, e_ra);
        chk({tag, ".rb_data"}, bus.rb_data, e_rb);
        chk({tag, ".hazard"},  {7'd0, bus.hazard}, {7'd0, e_hz});
        chk({tag, ".out_reg"}, bus.out_reg, e_out);
    endtask

    initial begin
        // Each row: inputs presented, one edge, then outputs checked with the row's read addresses.
        //            v     wa    wd      ra    rb    e_ra    e_rb    hz    out
        vecs[0]  = '{1'b1, 3'd3, 8'h5A, 3'd3, 3'd0, 8'h00, 8'h00, 1'b1, 8'h00};
        vecs[1]  = '{1'b0, 3'd0, 8'h00, 3'd3, 3'd3, 8'h5A, 8'h5A, 1'b0, 8'h00};
        vecs[2]  = '{1'b1, 3'd0, 8'h7F, 3'd0, 3'd3, 8'h00, 8'h5A, 1'b0, 8'h00};
        vecs[3]  = '{1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 8'h00, 8'h00, 1'b0, 8'h00};
        vecs[4]  = '{1'b1, 3'd7, 8'h81, 3'd7, 3'd3, 8'h00, 8'h5A, 1'b1, 8'h00};
        vecs[5]  = '{1'b1, 3'd7, 8'h02, 3'd7, 3'd1, 8'h81, 8'h00, 1'b1, 8'h81};
        vecs[6]  = '{1'b0, 3'd0, 8'h00, 3'd7, 3'd7, 8'h02, 8'h02, 1'b0, 8'h02};
        vecs[7]  = '{1'b1, 3'd2, 8'hC0, 3'd1, 3'd4, 8'h00, 8'h00, 1'b0, 8'h02};
        vecs[8]  = '{1'b1, 3'd4, 8'h11, 3'd2, 3'd2, 8'hC0, 8'hC0, 1'b0, 8'h02};
        vecs[9]  = '{1'b0, 3'd0, 8'h00, 3'd4, 3'd2, 8'h11, 8'hC0, 1'b0, 8'h02};
        vecs[10] = '{1'b1, 3'd1, 8'hFF, 3'd5, 3'd1, 8'h00, 8'h00, 1'b1, 8'h02};
        vecs[11] = '{1'b0, 3'd0, 8'h00, 3'd1, 3'd6, 8'hFF, 8'h00, 1'b0, 8'h02};

        // Reset, then every register on both ports reads zero.
        drive(1'b0, 3'd0, 8'h00, 3'd0, 3'd0);
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            drive(1'b0, 3'd0, 8'h00, 3'(i), 3'(NREG - 1 - i));
            #1;
            chk_all($sformatf("reset_r%0d", i), 8'h00, 8'h00, 1'b0, 8'h00);
        end

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].v, vecs[i].wa, vecs[i].wd, vecs[i].ra, vecs[i].rb);
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].e_ra, vecs[i].e_rb, vecs[i].e_hz, vecs[i].e_out);
        end

        // Both ports on r2 (0xC0 = -64) in the same cycle, as signed values.
        drive(1'b0, 3'd0, 8'h00, 3'd2, 3'd2);
        #1;
        n_total++;
        if (bus.ra_data == -8'sd64 && bus.rb_data == -8'sd64) n_pass++;
        else $display("FAIL signed_r2: got %0d/%0d, expected -64/-64", bus.ra_data, bus.rb_data);

        // Write to r5 presented on the very edge reset is asserted: dropped, everything cleared.
        drive(1'b1, 3'd5, 8'h33, 3'd5, 3'd7);
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive(1'b0, 3'd0, 8'h00, 3'd5, 3'd7);
        #1;
        chk_all("rst_same_edge", 8'h00, 8'h00, 1'b0, 8'h00);
        step();
        chk_all("rst_same_edge_after", 8'h00, 8'h00, 1'b0, 8'h00);

        // Write already sitting in the stage when reset hits: never committed.
        drive(1'b1, 3'd6, 8'h44, 3'd6, 3'd0);
        step();
        chk_all("pending_before_rst", 8'h00, 8'h00, 1'b1, 8'h00);
        drive(1'b0, 3'd0, 8'h00, 3'd6, 3'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        chk_all("pending_dropped", 8'h00, 8'h00, 1'b0, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
